// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between the instruction-fetch
// port and the load/store port. It keeps one transaction outstanding at a
// time. Data has priority, but a waiting fetch is served after at most
// MAX_D_BURST consecutive data grants.
//
// Handshake: a requester holds x_req and its payload steady until it sees
// the one-cycle x_ready pulse. The payload is captured when the grant is
// made, so it may change in any cycle after x_ready. The response comes
// back later as a one-cycle x_rvalid pulse, with x_rdata valid in that
// same cycle. Toward the RAM, m_en is a one-cycle command strobe that
// carries the payload. m_rvalid is accepted only while waiting for that
// command; a pulse at any other time is ignored.
module mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int MAX_D_BURST = 4
) (
    input  logic                clk,
    input  logic                rst,
    // instruction-fetch port
    input  logic                i_req,
    input  logic [ADDR_W-1:0]   i_addr,
    output logic                i_ready,
    output logic                i_rvalid,
    output logic [DATA_W-1:0]   i_rdata,
    // load/store port
    input  logic                d_req,
    input  logic                d_wen,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_wmask,
    output logic                d_ready,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    // memory side
    output logic                m_en,
    output logic                m_wen,
    output logic [ADDR_W-1:0]   m_addr,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wmask,
    input  logic                m_rvalid,
    input  logic [DATA_W-1:0]   m_rdata,
    // FSM state, for observation only
    output logic [1:0]          dbg_state
);

    localparam int SW = $clog2(MAX_D_BURST + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_D_BURST);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              state;
    logic                gnt_d;      // 1 = current transaction belongs to data port
    logic [SW-1:0]       streak;     // consecutive data grants made while fetch waited
    logic                lat_wen;
    logic [ADDR_W-1:0]   lat_addr;
    logic [DATA_W-1:0]   lat_wdata;
    logic [DATA_W/8-1:0] lat_wmask;
    logic [DATA_W-1:0]   i_rdata_q;  // separate holders so each port's rdata
    logic [DATA_W-1:0]   d_rdata_q;  // keeps its own last value

    // Arbitration, payload capture, and transaction sequencing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            gnt_d     <= 1'b0;
            streak    <= '0;
            lat_wen   <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_wmask <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Data wins unless the fetch has already waited a full burst.
                    if (d_req && !(i_req && streak == STREAK_MAX)) begin
                        gnt_d     <= 1'b1;
                        lat_wen   <= d_wen;
                        lat_addr  <= d_addr;
                        lat_wdata <= d_wdata;
                        lat_wmask <= d_wmask;
                        if (!i_req)
                            streak <= '0;
                        else if (streak != STREAK_MAX)
                            streak <= streak + 1'b1;
                        state     <= S_ISSUE;
                    end else if (i_req) begin
                        gnt_d     <= 1'b0;
                        lat_wen   <= 1'b0;
                        lat_addr  <= i_addr;
                        lat_wdata <= '0;
                        lat_wmask <= '0;
                        streak    <= '0;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: state <= S_WAIT;
                S_WAIT: begin
                    if (m_rvalid) begin
                        if (gnt_d)
                            d_rdata_q <= m_rdata;
                        else
                            i_rdata_q <= m_rdata;
                        state <= S_RESP;
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobes come straight from the state register. Payload and data come from latches.
    always_comb begin
        m_en      = (state == S_ISSUE);
        i_ready   = m_en && !gnt_d;
        d_ready   = m_en && gnt_d;
        i_rvalid  = (state == S_RESP) && !gnt_d;
        d_rvalid  = (state == S_RESP) && gnt_d;
        m_wen     = lat_wen;
        m_addr    = lat_addr;
        m_wdata   = lat_wdata;
        m_wmask   = lat_wmask;
        i_rdata   = i_rdata_q;
        d_rdata   = d_rdata_q;
        dbg_state = state;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: table of single transactions plus
// hand-written sequences for arbitration, stray completions and reset.
module tb_mem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MW = DW / 8;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          i_req, i_ready, i_rvalid;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          d_req, d_wen, d_ready, d_rvalid;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata, d_rdata;
    logic [MW-1:0] d_wmask;
    logic          m_en, m_wen, m_rvalid;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;
    logic [MW-1:0] m_wmask;
    logic [1:0]    dbg_state;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_BURST(4)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready),
        .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_wen(d_wen), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_wmask(d_wmask), .d_ready(d_ready), .d_rvalid(d_rvalid),
        .d_rdata(d_rdata),
        .m_en(m_en), .m_wen(m_wen), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_wmask(m_wmask), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
        .dbg_state(dbg_state)
    );

    // ---------------- scoreboard ----------------
    int checks   = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] last_i_rdata = '0;
    logic [DW-1:0] last_d_rdata = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic          is_d;
        logic          wen;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [MW-1:0] wmask;
        int            lat;
        logic [DW-1:0] mdata;
        logic          exp_wen;
        logic [MW-1:0] exp_wmask;
        logic [DW-1:0] exp_rdata;
    } vec_t;

    vec_t vecs [5];

    // ---------------- driver tasks ----------------
    // Runs one transaction. Call it #1 after a clock edge, with the DUT idle.
    task automatic do_txn(input vec_t v);
        i_req   = !v.is_d;
        d_req   = v.is_d;
        i_addr  = v.addr;
        d_addr  = v.addr;
        d_wen   = v.wen;
        d_wdata = v.wdata;
        d_wmask = v.wmask;
        exp_q.push_back(v.exp_rdata);
        step();  // T+1
        chk("issue_m_en", m_en, 1'b1);
        chk("issue_ready", v.is_d ? d_ready : i_ready, 1'b1);
        chk("issue_other_ready", v.is_d ? i_ready : d_ready, 1'b0);
        chk("issue_m_addr", m_addr, v.addr);
        chk("issue_m_wen", m_wen, v.exp_wen);
        chk("issue_m_wmask", m_wmask, v.exp_wmask);
        if (v.is_d && v.wen) chk("issue_m_wdata", m_wdata, v.wdata);
        i_req  = 1'b0;
        d_req  = 1'b0;
        i_addr = '1;
        d_addr = '1;
        for (int k = 1; k <= v.lat; k++) begin
            step();  // T+1+k
            chk("wait_m_en", m_en, 1'b0);
            chk("wait_ready", {i_ready, d_ready}, 2'b00);
            chk("wait_rvalid", {i_rvalid, d_rvalid}, 2'b00);
            if (k == v.lat) begin
                m_rvalid = 1'b1;
                m_rdata  = v.mdata;
            end
        end
        step();  // T+2+L
        m_rvalid = 1'b0;
        m_rdata  = '0;
        chk("resp_rvalid", v.is_d ? d_rvalid : i_rvalid, 1'b1);
        chk("resp_other_rvalid", v.is_d ? i_rvalid : d_rvalid, 1'b0);
        if (v.is_d) begin
            chk("resp_d_rdata", d_rdata, exp_q.pop_front());
            chk("hold_i_rdata", i_rdata, last_i_rdata);
            last_d_rdata = v.exp_rdata;
        end else begin
            chk("resp_i_rdata", i_rdata, exp_q.pop_front());
            chk("hold_d_rdata", d_rdata, last_d_rdata);
            last_i_rdata = v.exp_rdata;
        end
        step();  // T+3+L
        chk("back_idle", dbg_state, ST_IDLE);
        chk("idle_rvalid", {i_rvalid, d_rvalid}, 2'b00);
    endtask

    // Both ports request continuously; expect D,D,D,D,I twice at one m_en per 4 cycles.
    task automatic burst_seq();
        logic exp_g [10];
        int   n;
        int   last_en;
        logic prev_en;
        exp_g   = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        n       = 0;
        last_en = -1;
        prev_en = 1'b0;
        i_req   = 1'b1;
        d_req   = 1'b1;
        d_wen   = 1'b0;
        i_addr  = 32'h0000_1000;
        d_addr  = 32'h0000_2000;
        m_rdata = 32'h0000_0055;
        for (int cyc = 0; cyc < 60 && n < 10; cyc++) begin
            step();
            if (i_ready && d_ready) chk("ready_excl", {i_ready, d_ready}, 2'b01);
            if (i_rvalid && d_rvalid) chk("rvalid_excl", {i_rvalid, d_rvalid}, 2'b01);
            m_rvalid = prev_en;
            prev_en  = m_en;
            if (m_en) begin
                chk($sformatf("burst_grant%0d_is_d", n), d_ready, exp_g[n]);
                if (last_en < 0) chk("burst_first_en", 64'(cyc), 64'd0);
                else chk($sformatf("burst_gap%0d", n), 64'(cyc - last_en), 64'd4);
                last_en = cyc;
                n++;
                if (n == 10) begin
                    i_req = 1'b0;
                    d_req = 1'b0;
                end
            end
        end
        chk("burst_grant_count", 64'(n), 64'd10);
        i_req = 1'b0;
        d_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            m_rvalid = prev_en;
            prev_en  = m_en;
        end
        m_rvalid = 1'b0;
        m_rdata  = '0;
        chk("burst_end_idle", dbg_state, ST_IDLE);
        last_i_rdata = 32'h0000_0055;
        last_d_rdata = 32'h0000_0055;
    endtask

    // ---------------- test ----------------
    initial begin
        // {is_d, wen, addr, wdata, wmask, lat, mdata, exp_wen, exp_wmask, exp_rdata}
        vecs[0] = '{1'b0, 1'b1, 32'h8000_0000, 32'h0, 4'hF, 1, 32'h0000_0013, 1'b0, 4'h0, 32'h0000_0013};
        vecs[1] = '{1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'h3, 3, 32'h0, 1'b1, 4'h3, 32'h0};
        vecs[2] = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 4'hF, 2, 32'h1234_5678, 1'b0, 4'hF, 32'h1234_5678};
        vecs[3] = '{1'b0, 1'b0, 32'h8000_0004, 32'h0, 4'h0, 4, 32'h00A0_0093, 1'b0, 4'h0, 32'h00A0_0093};
        vecs[4] = '{1'b1, 1'b1, 32'h8000_2000, 32'hCAFE_F00D, 4'hC, 1, 32'h0, 1'b1, 4'hC, 32'h0};

        rst = 1'b0;
        i_req = 1'b0; i_addr = '0;
        d_req = 1'b0; d_wen = 1'b0; d_addr = '0; d_wdata = '0; d_wmask = '0;
        m_rvalid = 1'b0; m_rdata = '0;
        step();
        step();
        chk("rst_state", dbg_state, ST_IDLE);
        chk("rst_strobes", {m_en, i_ready, d_ready, i_rvalid, d_rvalid}, 5'b0);
        chk("rst_m_payload", {m_wen, m_addr, m_wdata, m_wmask} == '0, 1'b1);
        chk("rst_rdata", {i_rdata, d_rdata}, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        step();

        for (int i = 0; i < 5; i++) do_txn(vecs[i]);

        burst_seq();

        // Simultaneous request with streak 0: data first, then fetch once d_req drops.
        i_req = 1'b1; i_addr = 32'h0000_3000;
        d_req = 1'b1; d_wen = 1'b0; d_addr = 32'h0000_4000;
        step();
        chk("same_d_ready", d_ready, 1'b1);
        chk("same_i_ready", i_ready, 1'b0);
        d_req = 1'b0;
        step();
        m_rvalid = 1'b1; m_rdata = 32'h0000_0077;
        step();
        m_rvalid = 1'b0;
        chk("same_d_rvalid", d_rvalid, 1'b1);
        chk("same_d_rdata", d_rdata, 32'h0000_0077);
        step();
        step();
        chk("same_then_i_ready", i_ready, 1'b1);
        chk("same_then_i_addr", m_addr, 32'h0000_3000);
        i_req = 1'b0;
        step();
        m_rvalid = 1'b1; m_rdata = 32'h0000_0088;
        step();
        m_rvalid = 1'b0;
        chk("same_i_rvalid", i_rvalid, 1'b1);
        chk("same_i_rdata", i_rdata, 32'h0000_0088);
        step();
        last_i_rdata = 32'h0000_0088;
        last_d_rdata = 32'h0000_0077;

        // The fetch grant must have cleared the streak: the full burst pattern repeats.
        burst_seq();

        // Stray m_rvalid in IDLE and in ISSUE.
        m_rvalid = 1'b1; m_rdata = 32'h0000_0BAD;
        step();
        m_rvalid = 1'b0;
        chk("stray_idle_state", dbg_state, ST_IDLE);
        chk("stray_idle_rvalid", {i_rvalid, d_rvalid}, 2'b00);
        i_req = 1'b1; i_addr = 32'h0000_0100;
        step();
        chk("stray_issue_ready", i_ready, 1'b1);
        i_req = 1'b0;
        m_rvalid = 1'b1; m_rdata = 32'h0000_0BAD;
        step();
        m_rvalid = 1'b0;
        chk("stray_issue_state", dbg_state, ST_WAIT);
        chk("stray_issue_rvalid", i_rvalid, 1'b0);
        step();
        chk("stray_still_wait", dbg_state, ST_WAIT);
        m_rvalid = 1'b1; m_rdata = 32'h0000_600D;
        step();
        m_rvalid = 1'b0;
        chk("stray_real_rvalid", i_rvalid, 1'b1);
        chk("stray_real_rdata", i_rdata, 32'h0000_600D);
        step();
        last_i_rdata = 32'h0000_600D;

        // Reset during WAIT aborts the transaction.
        d_req = 1'b1; d_wen = 1'b1; d_addr = 32'h0000_0200; d_wdata = 32'h1111_2222; d_wmask = 4'hF;
        step();
        d_req = 1'b0;
        step();
        chk("rst_mid_wait", dbg_state, ST_WAIT);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_state", dbg_state, ST_IDLE);
        chk("async_rst_strobes", {m_en, i_ready, d_ready, i_rvalid, d_rvalid}, 5'b0);
        chk("async_rst_payload", {m_wen, m_addr, m_wdata, m_wmask} == '0, 1'b1);
        chk("async_rst_rdata", {i_rdata, d_rdata}, 64'h0);
        @(negedge clk);
        rst = 1'b1;
        step();
        m_rvalid = 1'b1; m_rdata = 32'hDEAD_0000;
        step();
        m_rvalid = 1'b0;
        chk("late_rvalid_state", dbg_state, ST_IDLE);
        chk("late_rvalid_out", {i_rvalid, d_rvalid}, 2'b00);
        chk("late_rvalid_rdata", {i_rdata, d_rdata}, 64'h0);
        last_i_rdata = '0;
        last_d_rdata = '0;
        do_txn(vecs[0]);

        chk("exp_q_empty", 64'(exp_q.size()), 64'd0);

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port memory between the CPU instruction-fetch port and its load/store port. Sits between the CPU and a unified RAM and owns all sequencing of that RAM. Keeps exactly one transaction outstanding: data first, with a bounded-starvation guarantee for fetch. Response latency from the memory is variable, at least 1 cycle.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; wmask width is DATA_W/8
- MAX_D_BURST, 4, consecutive data grants allowed while a fetch waits (≥1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held with i_addr until i_ready
- i_addr  in  ADDR_W  fetch address
- i_ready  out  1  one-cycle accept pulse
- i_rvalid  out  1  one-cycle response pulse
- i_rdata  out  DATA_W  fetched instruction, valid with i_rvalid
- d_req  in  1  data request; held with payload until d_ready
- d_wen  in  1  1 = write, 0 = read
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_wmask  in  DATA_W/8  byte-write mask
- d_ready  out  1  one-cycle accept pulse
- d_rvalid  out  1  one-cycle response pulse (also write ack)
- d_rdata  out  DATA_W  read data, valid with d_rvalid (0 for writes is not required)
- m_en  out  1  memory command strobe, exactly one cycle per transaction
- m_wen, m_addr, m_wdata, m_wmask  out  memory command payload, valid with m_en
- m_rvalid  in  1  memory completion (read data or write ack)
- m_rdata  in  DATA_W  memory read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs are decoded from state and internal registers.
- IDLE: samples i_req and d_req.
  - No request: stay in IDLE.
  - One request: grant that requester.
  - Both requests: grant data unless streak == MAX_D_BURST, in which case grant fetch.
- On grant: latch the requester ID and payload, then go to ISSUE. A fetch latches m_wen=0 and m_wmask=0.
- ISSUE: m_en=1 with the latched payload. The granted requester's x_ready=1. Always go to WAIT.
- WAIT: on m_rvalid, latch m_rdata and go to RESP. Otherwise stay in WAIT; there is no timeout.
- RESP: the granted requester's x_rvalid=1 and x_rdata = latched data. Always go to IDLE.
- req is sampled only in IDLE. The requester may change its payload in any cycle after its x_ready. m_rvalid outside WAIT is ignored.
- streak counter, $clog2(MAX_D_BURST+1) bits, updated on each grant:
  - fetch grant: clear to 0.
  - data grant with i_req=1: increment, saturating at MAX_D_BURST.
  - data grant with i_req=0: clear to 0.
- rdata outputs hold their last value outside RESP.

## Timing
- Reset (rst=0, asynchronous):
  - state = IDLE, streak = 0, all latched payload and data registers = 0.
  - m_en, i_ready, d_ready, i_rvalid, d_rvalid = 0; all data and address outputs = 0.
- Per transaction, with request seen in IDLE at cycle T:
  - T+1: m_en and x_ready.
  - First m_rvalid no earlier than T+2, at cycle T+1+L with L≥1.
  - T+2+L: x_rvalid.
  - T+3+L: back in IDLE; the next m_en is no earlier than T+4+L.
- Peak throughput with L=1: one transaction per 4 cycles.
- i_ready and d_ready are never high in the same cycle; likewise i_rvalid and d_rvalid.
- Reset mid-transaction aborts it; no x_rvalid is produced. A late m_rvalid after reset lands in IDLE and is ignored.
- Fetch worst-case wait with continuous data traffic: MAX_D_BURST data transactions, then the fetch is granted.

## Test plan
- Single fetch, i_addr=0x8000_0000, memory L=1 returning 0x0000_0013:
  - m_en and i_ready at T+1; i_rvalid with i_rdata=0x0000_0013 at T+3.
  - d_ready and d_rvalid stay 0.
- Data write, d_addr=0x8000_1000, d_wdata=0xDEAD_BEEF, d_wmask=0x3, L=3:
  - m_en=1, m_wen=1, m_wmask=0x3 at T+1 only; d_rvalid at T+5.
- Both requesting continuously, MAX_D_BURST=4, L=1:
  - grant order D,D,D,D,I,D,D,D,D,I.
  - Exactly one m_en every 4 cycles.
- d_req and i_req rising in the same IDLE cycle with streak=0: data is granted first. The fetch is granted next if d_req is deasserted, with streak cleared.
- Stray m_rvalid in IDLE and in ISSUE: no state change and no x_rvalid. A later in-WAIT m_rvalid completes normally.
- rst pulled low during WAIT:
  - all outputs go to 0 asynchronously.
  - m_rvalid arriving after rst rises is ignored; a new i_req is served normally.
